// File: rtl/fft_twiddle_pkg.sv
// fft_twiddle_pkg -- shared types and helpers for the FFT twiddle sequencer.
//
// Contents:
//   state_t    sequencer FSM state (IDLE, RUN)
//   WORD_BITS  default fixed-point word width
//   word_t     signed fixed-point word of the default width
//   log2_size  number of radix-2 stages for an N-point FFT
package fft_twiddle_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int WORD_BITS = 32;

  typedef logic signed [WORD_BITS-1:0] word_t;

  function automatic int log2_size(input int size_fft);
    return $clog2(size_fft);
  endfunction

endpackage

// File: rtl/twiddle_index_calc.sv
// twiddle_index_calc -- combinational twiddle table addressing.
//
// For butterfly j in radix-2 stage s, the twiddle exponent is
// (j mod 2^s) << (LOG2_SIZE-1-s). The cosine term is read a quarter
// period later in the sine table, i.e. at (idx + N/4) mod N.
//
// Ports:
//   j        in   butterfly index within the stage, 0..N/2-1
//   s        in   stage number, must already be clamped to < LOG2_SIZE
//   idx      out  sine table address for the imaginary part
//   idx_cos  out  sine table address for the real part
module twiddle_index_calc
  import fft_twiddle_pkg::*;
#(
  parameter int SIZE_FFT = 16,
  localparam int LOG2_SIZE = log2_size(SIZE_FFT),
  localparam int STAGE_W = $clog2(LOG2_SIZE),
  localparam int J_W = LOG2_SIZE - 1
) (
  input  logic [J_W-1:0]       j,
  input  logic [STAGE_W-1:0]   s,
  output logic [LOG2_SIZE-1:0] idx,
  output logic [LOG2_SIZE-1:0] idx_cos
);

  localparam int QUARTER = SIZE_FFT / 4;

  logic [LOG2_SIZE-1:0] masked;
  logic [STAGE_W-1:0]   shamt;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    masked = '0;
    for (int b = 0; b < J_W; b++) begin
      if (b < int'(s)) masked[b] = j[b];
    end
    // s < LOG2_SIZE is guaranteed upstream, so this never underflows.
    shamt   = STAGE_W'(LOG2_SIZE - 1) - s;
    idx     = masked << shamt;
    // Natural LOG2_SIZE-bit wrap performs the mod N.
    idx_cos = idx + LOG2_SIZE'(QUARTER);
  end

endmodule

// File: rtl/fft_twiddle_sequencer.sv
// fft_twiddle_sequencer -- streams the N/2 twiddle factors of one radix-2
// FFT stage, W = cos(theta) - j*sin(theta), in butterfly order.
//
// Optional feature macro: FFT_TWIDDLE_INVERSE_EN adds inverse_in; when the
// latched value is 1 the imaginary part is +sin (conjugate twiddles, IFFT).
//
// Ports:
//   clk           in   clock
//   reset         in   asynchronous active-high reset
//   sine_wave_in  in   sine table, entry i = sin(2*pi*i/N) * 2^DECIMAL_POINT
//   stage_in      in   stage to generate (clamped to LOG2_SIZE-1)
//   start_val     in   request valid
//   inverse_in    in   (macro only) request conjugate twiddles
//   start_rdy     out  idle, request accepted when start_val is high
//   twiddle_real  out  cos component
//   twiddle_imag  out  -sin component (+sin when inverse)
//   out_val       out  twiddle outputs valid
//   out_rdy       in   consumer accepts the current twiddle
//   done          out  one-cycle pulse after the last twiddle is accepted
module fft_twiddle_sequencer
  import fft_twiddle_pkg::*;
#(
  parameter int BIT_WIDTH     = 32,
  parameter int DECIMAL_POINT = 16,
  parameter int SIZE_FFT      = 16,
  localparam int LOG2_SIZE = log2_size(SIZE_FFT),
  localparam int STAGE_W   = $clog2(LOG2_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] sine_wave_in [0:SIZE_FFT-1],
  input  logic [STAGE_W-1:0]   stage_in,
  input  logic                 start_val,
`ifdef FFT_TWIDDLE_INVERSE_EN
  input  logic                 inverse_in,
`endif
  output logic                 start_rdy,
  output logic [BIT_WIDTH-1:0] twiddle_real,
  output logic [BIT_WIDTH-1:0] twiddle_imag,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic                 done
);

  localparam int HALF = SIZE_FFT / 2;
  localparam int J_W  = LOG2_SIZE - 1;

  if (SIZE_FFT < 4 || (SIZE_FFT & (SIZE_FFT - 1)) != 0) begin : g_bad_size
    $error("SIZE_FFT must be a power of two and at least 4");
  end
  if (DECIMAL_POINT >= BIT_WIDTH) begin : g_bad_point
    $error("DECIMAL_POINT must be smaller than BIT_WIDTH");
  end

  state_t             state;
  logic [J_W-1:0]     j_q;
  logic [STAGE_W-1:0] stage_q;

  logic [STAGE_W-1:0]   stage_clamped;
  logic [STAGE_W-1:0]   calc_s;
  logic [J_W-1:0]       calc_j;
  logic                 calc_inv;
  logic [LOG2_SIZE-1:0] idx;
  logic [LOG2_SIZE-1:0] idx_cos;
  logic [BIT_WIDTH-1:0] real_next;
  logic [BIT_WIDTH-1:0] imag_next;

`ifdef FFT_TWIDDLE_INVERSE_EN
  logic inverse_q;
`endif

  // The index calculator always addresses the word the output register is
  // about to load: j = 0 with the incoming stage on a start, j+1 with the
  // latched stage on a transfer.
  always_comb begin
    stage_clamped = stage_in;
    if (int'(stage_in) >= LOG2_SIZE) stage_clamped = STAGE_W'(LOG2_SIZE - 1);
    if (state == IDLE) begin
      calc_j = '0;
      calc_s = stage_clamped;
    end else begin
      calc_j = j_q + J_W'(1);
      calc_s = stage_q;
    end
  end

`ifdef FFT_TWIDDLE_INVERSE_EN
  assign calc_inv = (state == IDLE) ? inverse_in : inverse_q;
`else
  assign calc_inv = 1'b0;
`endif

  twiddle_index_calc #(
    .SIZE_FFT (SIZE_FFT)
  ) u_index (
    .j       (calc_j),
    .s       (calc_s),
    .idx     (idx),
    .idx_cos (idx_cos)
  );

  assign real_next = sine_wave_in[idx_cos];
  assign imag_next = calc_inv ? sine_wave_in[idx] : ('0 - sine_wave_in[idx]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      start_rdy    <= 1'b1;
      out_val      <= 1'b0;
      done         <= 1'b0;
      twiddle_real <= '0;
      twiddle_imag <= '0;
      j_q          <= '0;
      stage_q      <= '0;
`ifdef FFT_TWIDDLE_INVERSE_EN
      inverse_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_val) begin
            state        <= RUN;
            start_rdy    <= 1'b0;
            out_val      <= 1'b1;
            j_q          <= '0;
            stage_q      <= stage_clamped;
`ifdef FFT_TWIDDLE_INVERSE_EN
            inverse_q    <= inverse_in;
`endif
            twiddle_real <= real_next;
            twiddle_imag <= imag_next;
          end
        end
        RUN: begin
          if (out_val && out_rdy) begin
            if (j_q == J_W'(HALF - 1)) begin
              // Output words persist; only out_val drops.
              state     <= IDLE;
              start_rdy <= 1'b1;
              out_val   <= 1'b0;
              done      <= 1'b1;
            end else begin
              j_q          <= calc_j;
              twiddle_real <= real_next;
              twiddle_imag <= imag_next;
            end
          end
        end
        default: begin
          state     <= IDLE;
          start_rdy <= 1'b1;
          out_val   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fft_twiddle_sequencer.md
Name: fft_twiddle_sequencer

Overview:
- Sequential stage directly downstream of the sine-wave lookup table.
- Takes the SIZE_FFT-entry fixed-point sine table and a requested FFT stage.
- Streams the N/2 complex twiddle factors W = cos(θ) − j·sin(θ), one per butterfly, in butterfly order over a val/rdy handshake.
- Output feeds the butterfly array's twiddle input port.

Parameters:
- BIT_WIDTH, 32, width of each fixed-point word (two's complement).
- DECIMAL_POINT, 16, fractional bits; 1.0 = 2^DECIMAL_POINT. Pass-through only, no arithmetic depends on it.
- SIZE_FFT, 16, FFT points N; power of two, ≥ 4.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- sine_wave_in  in  BIT_WIDTH × [0:SIZE_FFT-1]  sine table; entry i = sin(2πi/N)·2^DECIMAL_POINT. Static during operation.
- stage_in  in  $clog2(LOG2_SIZE)  stage to generate, 0 = first radix-2 stage.
- start_val  in  1  request valid.
- start_rdy  out  1  block idle and able to accept a request.
- twiddle_real  out  BIT_WIDTH  cos component.
- twiddle_imag  out  BIT_WIDTH  −sin component.
- out_val  out  1  twiddle outputs valid.
- out_rdy  in  1  consumer accepts.
- done  out  1  one-cycle pulse after the last twiddle is accepted.

Behaviour:
- LOG2_SIZE = $clog2(SIZE_FFT). HALF = N/2. QUARTER = N/4.
- FSM states: IDLE, RUN.
- Reset values:
  - state = IDLE, start_rdy = 1, out_val = 0, done = 0.
  - twiddle_real = 0, twiddle_imag = 0.
  - counter j = 0, stored stage = 0.
- IDLE:
  - start_rdy = 1.
  - On start_val: latch stage_in, clamping any value ≥ LOG2_SIZE to LOG2_SIZE−1.
  - Set j = 0 and go to RUN.
  - First out_val appears the next cycle (latency 1).
- RUN:
  - start_rdy = 0; start_val is ignored.
  - Output register holds index j. Twiddle index idx = (j mod 2^s) << (LOG2_SIZE−1−s), where s is the latched stage.
  - twiddle_real = sine_wave_in[(idx + QUARTER) mod N].
  - twiddle_imag = 0 − sine_wave_in[idx], in BIT_WIDTH two's-complement wrap. Table magnitudes ≤ 2^DECIMAL_POINT, so no overflow in practice.
- Handshake:
  - Transfer happens when out_val && out_rdy.
  - Outputs and out_val hold stable while out_val && !out_rdy.
  - Throughput is one twiddle per cycle under continuous out_rdy.
- Last transfer (j == HALF−1):
  - Next cycle: out_val = 0, done = 1 for exactly one cycle, state = IDLE, start_rdy = 1.
  - A start_val in that same cycle is accepted, so back-to-back requests incur a one-cycle bubble.
- Output register values persist after the last transfer; only out_val drops.
- Reset asserted mid-run: immediate asynchronous return to reset values; no done pulse.
- sine_wave_in is sampled combinationally into the output register on every load; changing it mid-run is undefined.

Optional Feature:
- Macro FFT_TWIDDLE_INVERSE_EN.
- When defined:
  - Add input port inverse_in (1 bit), latched with stage_in on start.
  - When the latched value is 1, twiddle_imag = +sine_wave_in[idx], giving conjugate twiddles for the IFFT.
  - twiddle_real is unchanged.
- When undefined:
  - No port is added.
  - twiddle_imag is always −sin.

Decomposition:
- Shared package fft_twiddle_pkg:
  - state enum {IDLE, RUN}.
  - Helper function log2 size.
  - Typedef for a BIT_WIDTH signed word.
- One natural sub-module: twiddle_index_calc.
  - Combinational; inputs j and s.
  - Outputs idx and (idx+QUARTER) mod N.
  - Instantiated once.
- FSM, counter and output register live in the top module.

Test Plan (N=16, table 0, 25079, 46340, 60547, 65536, … per standard sin×65536):
- Reset, then start stage 0 with out_rdy = 1 → out_val from the next cycle for 8 consecutive cycles, every word real = 65536 and imag = 0. Then done pulses once and start_rdy returns to 1.
- Start stage 3 → j = 0..7 gives (65536, 0), (60547, −25079 = 0xFFFF9E09), (46340, −46340), (25079, −60547), (0, −65536), (−25079, −60547), (−46340, −46340), (−60547, −25079).
- Start stage 1 → pattern alternates (65536, 0), (0, −65536), repeated 4 times.
- Stage 3 with out_rdy toggled 1,0,0,1,… → outputs are held stable during stalls, no word is skipped or duplicated, and 8 transfers total occur.
- Assert reset after 3 transfers → out_val = 0, start_rdy = 1 and done = 0 immediately. A fresh stage 2 request yields (65536, 0), (46340, −46340), (0, −65536), (−46340, −46340), repeated twice.
- start_val held high during RUN with stage_in changing → ignored. Start_val during the done cycle → accepted, and the new stream begins the following cycle. With FFT_TWIDDLE_INVERSE_EN and inverse_in = 1 on stage 3: j = 1 gives imag = +25079.
